// File: rtl/pc11_tape_regs.sv
// +----------------------------------------------------------------------------+
// | pc11_tape_regs: PC11 paper-tape register file bridging CPU to SD emulator.  |
// | Optional macro PC11_AUTOFLUSH_EN builds the idle auto-flush timer. Rev 1.0  |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pc11_tape_regs #(
  parameter logic [21:0] BASE_ADDR     = 22'o17777550,
  parameter int unsigned FLUSH_TIMEOUT = 27_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [21:0] i_addr,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [1:0]  i_byte_en,
  input  logic [15:0] i_wdata,
  output logic        o_hit,
  output logic [15:0] o_rdata,
  output logic        o_rdr_irq,
  output logic        o_pun_irq,
  output logic        o_tape_read,
  output logic        o_tape_punch,
  output logic [7:0]  o_tape_punch_data,
  output logic        o_tape_clear_done,
  output logic        o_tape_flush,
  input  logic        i_tape_read_busy,
  input  logic        i_tape_read_done,
  input  logic        i_tape_punch_ready,
  input  logic [7:0]  i_tape_read_data,
  input  logic [3:0]  i_sd_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] REG_PRS = 2'd0;
  localparam logic [1:0] REG_PRB = 2'd1;
  localparam logic [1:0] REG_PPS = 2'd2;
  localparam logic [1:0] REG_PPB = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  hold_cnt_q, hold_cnt_d;
  logic        rd_pend_q, rd_pend_d, pp_pend_q, pp_pend_d, fl_pend_q, fl_pend_d;
  logic        rd_out_q, rd_out_d, pp_out_q, pp_out_d;
  logic        ie_rdr_q, ie_rdr_d, ie_pun_q, ie_pun_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rdr_irq_q, rdr_irq_d, pun_irq_q, pun_irq_d;
  logic        tape_read_q, tape_read_d, tape_punch_q, tape_punch_d;
  logic        tape_flush_q, tape_flush_d, clear_done_q, clear_done_d;
  logic [7:0]  punch_data_q, punch_data_d;

  logic        err, busy, ready, acc_wr, acc_rd, can_issue;
  logic        issue_rd, issue_pp, issue_fl, auto_flush;
  logic [1:0]  sel;

  assign o_hit = (i_addr[21:3] == BASE_ADDR[21:3]);

  always_comb begin
    err       = |i_sd_error;
    busy      = rd_pend_q | rd_out_q;
    ready     = !pp_pend_q && !pp_out_q;
    sel       = i_addr[2:1];
    acc_wr    = i_wr && o_hit && i_byte_en[0];
    acc_rd    = i_rd && o_hit;
    can_issue = (state_q == ST_IDLE) && i_tape_punch_ready && !err;
    // Fixed priority: read, then punch, then flush.
    issue_rd  = can_issue && rd_pend_q;
    issue_pp  = can_issue && !rd_pend_q && pp_pend_q;
    issue_fl  = can_issue && !rd_pend_q && !pp_pend_q && fl_pend_q;
  end

`ifdef PC11_AUTOFLUSH_EN
  localparam int unsigned CNT_W = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             unflushed_q, unflushed_d;

  // Fires two cycles early: one for fl_pend to register, one for the issue flop,
  // so the flush pulse lands exactly FLUSH_TIMEOUT cycles after the punch pulse.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    unflushed_d = unflushed_q;
    auto_flush  = 1'b0;
    if (issue_pp) begin
      idle_cnt_d  = '0;
      unflushed_d = 1'b1;
    end else if (unflushed_q) begin
      if (idle_cnt_q == CNT_W'(FLUSH_TIMEOUT - 2)) begin
        auto_flush = 1'b1;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + CNT_W'(1);
      end
    end
    if (issue_fl) unflushed_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      idle_cnt_q  <= '0;
      unflushed_q <= 1'b0;
    end else begin
      idle_cnt_q  <= idle_cnt_d;
      unflushed_q <= unflushed_d;
    end
  end
`else
  assign auto_flush = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    rd_pend_d    = rd_pend_q;
    pp_pend_d    = pp_pend_q;
    fl_pend_d    = fl_pend_q;
    rd_out_d     = rd_out_q;
    pp_out_d     = pp_out_q;
    ie_rdr_d     = ie_rdr_q;
    ie_pun_d     = ie_pun_q;
    punch_data_d = punch_data_q;
    tape_read_d  = 1'b0;
    tape_punch_d = 1'b0;
    tape_flush_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (issue_rd || issue_pp || issue_fl) state_d = ST_ISSUE;
        if (issue_rd) begin
          tape_read_d = 1'b1;
          rd_pend_d   = 1'b0;
          rd_out_d    = 1'b1;
        end
        if (issue_pp) begin
          tape_punch_d = 1'b1;
          pp_pend_d    = 1'b0;
          pp_out_d     = 1'b1;
        end
        if (issue_fl) begin
          tape_flush_d = 1'b1;
          fl_pend_d    = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d    = ST_HOLD;
        hold_cnt_d = 2'd2;
      end
      ST_HOLD: begin
        if (hold_cnt_q != 2'd0) begin
          hold_cnt_d = hold_cnt_q - 2'd1;
        end else if (i_tape_punch_ready) begin
          rd_out_d = 1'b0;
          pp_out_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Register writes come after the FSM so a flush strobe racing an issue survives.
    if (acc_wr) begin
      case (sel)
        REG_PRS: begin
          ie_rdr_d = i_wdata[6];
          if (i_wdata[0] && !busy && !err) rd_pend_d = 1'b1;
        end
        REG_PPS: begin
          ie_pun_d = i_wdata[6];
          if (i_wdata[0]) fl_pend_d = 1'b1;
        end
        REG_PPB: begin
          if (ready && !err) begin
            punch_data_d = i_wdata[7:0];
            pp_pend_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (auto_flush) fl_pend_d = 1'b1;

    if (err) begin
      rd_pend_d = 1'b0;
      pp_pend_d = 1'b0;
      fl_pend_d = 1'b0;
    end

    rdata_d = 16'h0000;
    if (acc_rd) begin
      case (sel)
        REG_PRS: rdata_d = {err, 3'b000, busy, 3'b000, i_tape_read_done, ie_rdr_q, 6'b000000};
        REG_PRB: rdata_d = {8'h00, i_tape_read_data};
        REG_PPS: rdata_d = {err, 7'b0000000, ready, ie_pun_q, 6'b000000};
        default: rdata_d = 16'h0000;
      endcase
    end
    clear_done_d = acc_rd && (sel == REG_PRB);
    rdr_irq_d    = ie_rdr_q && i_tape_read_done;
    pun_irq_d    = ie_pun_q && ready && !err;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= 2'd0;
      rd_pend_q    <= 1'b0;
      pp_pend_q    <= 1'b0;
      fl_pend_q    <= 1'b0;
      rd_out_q     <= 1'b0;
      pp_out_q     <= 1'b0;
      ie_rdr_q     <= 1'b0;
      ie_pun_q     <= 1'b0;
      rdata_q      <= 16'h0000;
      rdr_irq_q    <= 1'b0;
      pun_irq_q    <= 1'b0;
      tape_read_q  <= 1'b0;
      tape_punch_q <= 1'b0;
      tape_flush_q <= 1'b0;
      clear_done_q <= 1'b0;
      punch_data_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_pend_q    <= rd_pend_d;
      pp_pend_q    <= pp_pend_d;
      fl_pend_q    <= fl_pend_d;
      rd_out_q     <= rd_out_d;
      pp_out_q     <= pp_out_d;
      ie_rdr_q     <= ie_rdr_d;
      ie_pun_q     <= ie_pun_d;
      rdata_q      <= rdata_d;
      rdr_irq_q    <= rdr_irq_d;
      pun_irq_q    <= pun_irq_d;
      tape_read_q  <= tape_read_d;
      tape_punch_q <= tape_punch_d;
      tape_flush_q <= tape_flush_d;
      clear_done_q <= clear_done_d;
      punch_data_q <= punch_data_d;
    end
  end

  assign o_rdata           = rdata_q;
  assign o_rdr_irq         = rdr_irq_q;
  assign o_pun_irq         = pun_irq_q;
  assign o_tape_read       = tape_read_q;
  assign o_tape_punch      = tape_punch_q;
  assign o_tape_flush      = tape_flush_q;
  assign o_tape_clear_done = clear_done_q;
  assign o_tape_punch_data = punch_data_q;

  // Busy status is derived locally; the emulator busy line is informational.
  logic unused_inputs;
  assign unused_inputs = ^{i_addr[0], i_byte_en[1], i_wdata[15:8], i_tape_read_busy};

endmodule

`default_nettype wire
